uart_rx_fifo: RTL and testbench

UART receiver with a small receive FIFO, sitting inside the communication block between the board `RX` pin and the CPU-visible UART0 read register. It samples an asynchronous 8N1 serial line on the CPU master clock and assembles bytes. Complete bytes are buffered in a first-word-fall-through FIFO. It exposes a read/acknowledge handshake, sticky error flags and a level interrupt, which the communication block uses to drive its interrupt line.

---
 rtl/uart_rx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with first-word-fall-through receive FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_ack,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy,
    output logic                          interrupt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic       rx_s1, rx_s2, rx_prev;
    logic [1:0] primed;
    logic       fall;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic        push, ferr_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, push_ok, pop_ok;
    logic [CW-1:0] count_n;

    // rx_prev only learns a high level once rx_s2 holds a real post-reset sample,
    // so a line stuck low across reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b0;
            primed  <= 2'b00;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            primed  <= {primed[0], 1'b1};
            rx_prev <= primed[1] & rx_s2;
        end
    end

    assign fall = rx_prev & ~rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 16'd1;
        idx_n    = idx;
        shift_n  = shift;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s2;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n    = '0;
                    state_n  = IDLE;
                    push     = rx_s2;
                    ferr_set = ~rx_s2;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign rd_valid = (count != '0);
    assign pop_ok   = rd_ack & rd_valid;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push & (~full | pop_ok);
    assign count_n  = count + CW'(push_ok) - CW'(pop_ok);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_n;
            interrupt <= (count_n != '0);
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (push & ~push_ok) overrun <= 1'b1;
            else if (clr_err)    overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo at 8 clocks per bit
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst, rx, rd_ack, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid, frame_err, overrun, busy, interrupt;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_ack(rd_ack), .clr_err(clr_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .frame_err(frame_err), .overrun(overrun), .busy(busy), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic send_bits(input logic [7:0] d);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bits(d);
        rx = stop;
        repeat (8) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pop_one;
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b0; rd_ack = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %0h want 00", rd_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if ({rd_valid, frame_err, overrun, busy, interrupt} !== 5'b0) begin errors++;
            $display("FAIL reset_flags got %b want 00000", {rd_valid, frame_err, overrun, busy, interrupt}); end
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        checks++; if ({busy, rd_valid, frame_err} !== 3'b000) begin errors++;
            $display("FAIL line_low got busy/valid/ferr %b want 000", {busy, rd_valid, frame_err}); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_byte;
        send_bits(8'hA5);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        checks++; if ({busy, rd_valid} !== 2'b10) begin errors++;
            $display("FAIL stop_cycle got busy/valid %b want 10", {busy, rd_valid}); end
        @(negedge clk);
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got %0h want a5", rd_data); end
        checks++; if ({rd_valid, interrupt, busy} !== 3'b110) begin errors++;
            $display("FAIL single_flags got valid/int/busy %b want 110", {rd_valid, interrupt, busy}); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        pop_one();
        checks++; if ({rd_valid, interrupt, count} !== 5'b0) begin errors++;
            $display("FAIL single_pop got valid/int/count %b want 00000", {rd_valid, interrupt, count}); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start got busy %b want 1", busy); end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if ({busy, count, frame_err} !== 5'b0) begin errors++;
            $display("FAIL glitch_end got busy/count/ferr %b want 00000", {busy, count, frame_err}); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_frame_error;
        send_byte(8'h3C, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b want 1", frame_err); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ferr_count got %0d want 0", count); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", frame_err); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overrun;
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovr_count got %0d want 4", count); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL ovr_read got %0h want %0h", rd_data, exp); end
            pop_one();
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got %b want 0", rd_valid); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL refill_count got %0d want 4", count); end
        send_bits(8'h14);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        pop_one();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pushpop_count got %0d want 4", count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pushpop_ovr got %b want 0", overrun); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'h10 + 8'(i);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL pushpop_read got %0h want %0h", rd_data, exp); end
            pop_one();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL pushpop_empty got %0d want 0", count); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'h77, 1'b1);
        repeat (2) @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (28) @(negedge clk);
        checks++; if ({busy, count} !== 4'b1001) begin errors++;
            $display("FAIL pre_reset got busy/count %b want 1001", {busy, count}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({rd_valid, busy, interrupt, frame_err, overrun, count} !== 8'b0) begin errors++;
            $display("FAIL async_reset got %b want 00000000", {rd_valid, busy, interrupt, frame_err, overrun, count}); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL async_reset_data got %0h want 00", rd_data); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL after_reset_data got %0h want 5a", rd_data); end
        checks++; if ({count, frame_err} !== 4'b0010) begin errors++;
            $display("FAIL after_reset_state got count/ferr %b want 0010", {count, frame_err}); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
